// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Port ids: instruction fetch and load/store unit
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Operation encoding held in the latched request
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Latched request forwarded to the memory while BUSY
  typedef struct packed {
    logic        id;
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // A port asserting both read and write is treated as a write
  function automatic logic decode_op(input logic wr_en);
    return wr_en ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner pick between the fetch port and the load/store port.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller samples the grant only while idle.
// Build option ARB_ROUND_ROBIN_EN: contention goes to the port holding priority.
module arb_grant_sel
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic prio_i,
`endif
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  // Winner selection; a lone requester always wins
  always_comb begin
    gnt_vld_o = req0_i | req1_i;
    gnt_id_o  = PORT_IF;
    if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_id_o = prio_i;
`else
      gnt_id_o = PORT_LS;
`endif
    end else if (req1_i) begin
      gnt_id_o = PORT_LS;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port data memory between fetch (port 0) and load/store (port 1).
// Latency: with a combinational memory ack, the ack comes 2 cycles after the idle sample.
// Backpressure: requests are held as levels; the loser simply waits for the next idle cycle.
// Build option ARB_ROUND_ROBIN_EN: alternate on contention, otherwise port 1 always wins.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_rd_en_i,
  input  logic        m0_wr_en_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_rd_en_i,
  input  logic        m1_wr_en_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   resp_q, resp_d;
  logic          err_q, err_d;
  logic          gnt_vld, gnt_id;
`ifdef ARB_ROUND_ROBIN_EN
  logic          prio_q, prio_d;
`endif

  arb_grant_sel u_grant_sel (
    .req0_i    (m0_rd_en_i | m0_wr_en_i),
    .req1_i    (m1_rd_en_i | m1_wr_en_i),
`ifdef ARB_ROUND_ROBIN_EN
    .prio_i    (prio_q),
`endif
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  // Next-state: latch the winner in IDLE, wait for ack or timeout in BUSY, pulse in RESP
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    err_d   = err_q;
`ifdef ARB_ROUND_ROBIN_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (gnt_vld) begin
          req_d.id = gnt_id;
          if (gnt_id == PORT_LS) begin
            req_d.op    = decode_op(m1_wr_en_i);
            req_d.addr  = m1_addr_i;
            req_d.wdata = m1_data_i;
          end else begin
            req_d.op    = decode_op(m0_wr_en_i);
            req_d.addr  = m0_addr_i;
            req_d.wdata = m0_data_i;
          end
          err_d   = 1'b0;
          state_d = ST_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
          // Priority passes to the port that did not just win
          prio_d  = ~gnt_id;
`endif
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // Ack takes precedence over a timeout landing in the same cycle
        if (mem_ack_i) begin
          resp_d  = (req_q.op == OP_RD) ? mem_data_i : 32'h0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= 32'h0;
      err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_q  <= PORT_LS;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

  // Outputs decode registered state only; memory sees the latched request
  always_comb begin
    mem_rd_en_o = (state_q == ST_BUSY) && (req_q.op == OP_RD);
    mem_wr_en_o = (state_q == ST_BUSY) && (req_q.op == OP_WR);
    mem_addr_o  = req_q.addr;
    mem_data_o  = req_q.wdata;
    m0_ack_o    = (state_q == ST_RESP) && (req_q.id == PORT_IF);
    m1_ack_o    = (state_q == ST_RESP) && (req_q.id == PORT_LS);
    err_o       = (state_q == ST_RESP) && err_q;
    m0_data_o   = resp_q;
    m1_data_o   = resp_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small word memory model whose ack delay is programmable.
// Table rows cover single transactions; hand sequences cover address hold, reset mid-BUSY and contention.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_rd_en_i, m0_wr_en_i, m1_rd_en_i, m1_wr_en_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m1_ack_o;
  logic        mem_rd_en_o, mem_wr_en_o, mem_ack_i, err_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_en_i(m0_rd_en_i), .m0_wr_en_i(m0_wr_en_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_rd_en_i(m1_rd_en_i), .m1_wr_en_i(m1_wr_en_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_dly strobe cycles (0 = combinational), writes commit on ack
  logic [31:0] mem [64];
  logic        preload;
  logic        strobe;
  int          ack_dly;
  int          strobe_cyc = 0;

  assign strobe     = mem_rd_en_o | mem_wr_en_o;
  assign mem_ack_i  = strobe && (strobe_cyc >= ack_dly);
  assign mem_data_i = mem[mem_addr_o[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[12] <= 32'hCAFE0030;
      mem[16] <= 32'hBAD00040;
    end else if (mem_wr_en_o && mem_ack_i) begin
      mem[mem_addr_o[7:2]] <= mem_data_o;
    end
    if (strobe && !mem_ack_i) strobe_cyc <= strobe_cyc + 1;
    else                      strobe_cyc <= 0;
  end

  typedef struct {
    logic rd0; logic wr0; logic [31:0] a0; logic [31:0] d0;
    logic rd1; logic wr1; logic [31:0] a1; logic [31:0] d1;
    int dly; logic port; logic [31:0] data; logic err; int lat; logic [31:0] addr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic drop_all();
    m0_rd_en_i = 1'b0; m0_wr_en_i = 1'b0;
    m1_rd_en_i = 1'b0; m1_wr_en_i = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    logic        got;
    logic [31:0] seen;
    @(negedge clk);
    m0_rd_en_i = v.rd0; m0_wr_en_i = v.wr0; m0_addr_i = v.a0; m0_data_i = v.d0;
    m1_rd_en_i = v.rd1; m1_wr_en_i = v.wr1; m1_addr_i = v.a1; m1_data_i = v.d1;
    ack_dly = v.dly;
    lat = 0; got = 1'b0; seen = 32'hFFFF_FFFF;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (strobe) seen = mem_addr_o;
      if (m0_ack_o || m1_ack_o) got = 1'b1;
    end
    chk1($sformatf("v%0d_ack_seen", idx), got, 1'b1);
    if (got) begin
      chk1($sformatf("v%0d_m0_ack", idx), m0_ack_o, v.port == 1'b0);
      chk1($sformatf("v%0d_m1_ack", idx), m1_ack_o, v.port == 1'b1);
      chk($sformatf("v%0d_m0_data", idx), m0_data_o, v.data);
      chk($sformatf("v%0d_m1_data", idx), m1_data_o, v.data);
      chk1($sformatf("v%0d_err", idx), err_o, v.err);
      chk($sformatf("v%0d_latency", idx), lat, v.lat);
      chk($sformatf("v%0d_mem_addr", idx), seen, v.addr);
      chk1($sformatf("v%0d_strobes_off", idx), strobe, 1'b0);
    end
    drop_all();
  endtask

  logic exp_seq [4];

  initial begin
    int   k, cyc, last, n_ack, c0, c1;
    logic got, w;

    // rd0 wr0 a0 d0 | rd1 wr1 a1 d1 | dly | port data err lat addr
    vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        0,  1'b0, 32'hDEADBEEF, 1'b0, 2, 32'h10};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, 32'h20, 32'h12345678, 0,  1'b1, 32'h0,        1'b0, 2, 32'h20};
    vecs[2]  = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        0,  1'b0, 32'h12345678, 1'b0, 2, 32'h20};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 0,  1'b1, 32'h0,        1'b0, 2, 32'h24};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h24, 32'h0,        0,  1'b1, 32'hA5A5A5A5, 1'b0, 2, 32'h24};
    vecs[5]  = '{1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        0,  1'b0, 32'hDEADBEEF, 1'b0, 2, 32'h13};
    vecs[6]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0,        0,  1'b1, 32'hA5A5A5A5, 1'b0, 2, 32'h24};
    vecs[7]  = '{1'b0, 1'b1, 32'h28, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0, 99, 1'b0, 32'h0,        1'b1, 5, 32'h28};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h10, 32'h0,        99, 1'b1, 32'h0,        1'b1, 5, 32'h10};
    vecs[9]  = '{1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        0,  1'b0, 32'h0,        1'b0, 2, 32'h28};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h10, 32'h0,        3,  1'b1, 32'hDEADBEEF, 1'b0, 5, 32'h10};
    vecs[11] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        2,  1'b0, 32'h12345678, 1'b0, 4, 32'h20};

`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
`else
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b0;
`endif

    rst = 1'b1; preload = 1'b1; ack_dly = 0;
    drop_all();
    m0_addr_i = 32'h0; m0_data_i = 32'h0; m1_addr_i = 32'h0; m1_data_i = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk1("rst_m0_ack", m0_ack_o, 1'b0);
    chk1("rst_m1_ack", m1_ack_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_strobes", strobe, 1'b0);
    chk("rst_m0_data", m0_data_o, 32'h0);
    chk("rst_m1_data", m1_data_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    rst = 1'b0; preload = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Address change during BUSY must not reach the memory
    @(negedge clk);
    m1_rd_en_i = 1'b1; m1_addr_i = 32'h30; ack_dly = 2;
    k = 0; got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (strobe) chk($sformatf("hold_addr_c%0d", k), mem_addr_o, 32'h30);
      if (k == 1) m1_addr_i = 32'h40;
      if (m1_ack_o) got = 1'b1;
    end
    chk1("hold_ack_seen", got, 1'b1);
    chk("hold_data", m1_data_o, 32'hCAFE0030);
    chk("hold_latency", k, 4);
    drop_all();

    // Reset while BUSY aborts; the held request then completes normally
    @(negedge clk);
    m0_wr_en_i = 1'b1; m0_addr_i = 32'h2C; m0_data_i = 32'hAAAA5555; ack_dly = 99;
    @(negedge clk);
    chk1("rstbusy_wr_strobe", mem_wr_en_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("rstbusy_strobes", strobe, 1'b0);
    chk1("rstbusy_m0_ack", m0_ack_o, 1'b0);
    chk1("rstbusy_m1_ack", m1_ack_o, 1'b0);
    chk1("rstbusy_err", err_o, 1'b0);
    chk("rstbusy_resp", m0_data_o, 32'h0);
    chk("rstbusy_mem_uncommitted", mem[11], 32'h0);
    rst = 1'b0; ack_dly = 0;
    k = 0; got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (m0_ack_o || m1_ack_o) got = 1'b1;
    end
    chk1("rstbusy_ack_seen", got, 1'b1);
    chk1("rstbusy_ack_port0", m0_ack_o, 1'b1);
    chk("rstbusy_latency", k, 2);
    chk("rstbusy_mem_commit", mem[11], 32'hAAAA5555);
    drop_all();

    // Contention: both ports held across four transactions after a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_rd_en_i = 1'b1; m0_addr_i = 32'h10;
    m1_rd_en_i = 1'b1; m1_addr_i = 32'h24;
    cyc = 0; last = 0; n_ack = 0; c0 = 0; c1 = 0;
    while (n_ack < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m0_ack_o || m1_ack_o) begin
        w = m1_ack_o;
        chk1($sformatf("arb_port_%0d", n_ack), w, exp_seq[n_ack]);
        chk($sformatf("arb_gap_%0d", n_ack), cyc - last, (n_ack == 0) ? 2 : 3);
        chk($sformatf("arb_data_%0d", n_ack), m0_data_o,
            exp_seq[n_ack] ? 32'hA5A5A5A5 : 32'hDEADBEEF);
        last = cyc;
        n_ack++;
        if (w) begin
          c1++;
          if (c1 == 2) m1_rd_en_i = 1'b0;
        end else begin
          c0++;
          if (c0 == 2) m0_rd_en_i = 1'b0;
        end
      end
    end
    chk("arb_ack_count", n_ack, 4);
    drop_all();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
